alu_result_checker: RTL and testbench
=====================================

Name: alu_result_checker

Overview:
- Downstream monitor for the 4-bit trojan-capable ALU.
- Takes each ALU transaction (operands, opcode, observed res/cout) and recomputes the golden result in a 2-stage pipeline.
- Counts samples and mismatches, raises a sticky alarm at a threshold, and buffers mismatch records in a small FIFO for readout by host/scan logic.

Parameters:
- DEPTH, 4, mismatch FIFO entries (power of 2, >=2)
- CNT_W, 16, width of the sample and mismatch counters (saturating)
- ALARM_THRESH, 1, mismatch count at which alarm asserts (>=1)
- STALL_ON_FULL, 0, 1 = deassert in_ready while FIFO full; 0 = drop the record and flag overflow

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  asynchronous active-high reset
- clear  in  1  synchronous clear of counters, flags, FIFO and pipeline
- in_valid  in  1  transaction present
- in_ready  out  1  checker accepts transaction
- a  in  4  operand a
- b  in  4  operand b
- op  in  2  00 ADD, 01 SUB, 10 AND, 11 OR
- res  in  4  observed ALU result
- cout  in  1  observed ALU carry/borrow
- out_valid  out  1  mismatch record available
- out_ready  in  1  consumer pops record
- out_rec  out  20  {op[1:0], a, b, res, cout, exp_res[3:0], exp_cout}
- sample_cnt  out  CNT_W  accepted transactions
- mismatch_cnt  out  CNT_W  detected mismatches
- alarm  out  1  sticky, mismatch_cnt >= ALARM_THRESH
- overflow  out  1  sticky, a record was dropped

Behaviour:
- Reset (async, rst=1): all pipeline valids 0, FIFO empty, counters 0, alarm=0, overflow=0, out_valid=0, out_rec=0.
  - in_ready=1 out of reset: combinational, low only when STALL_ON_FULL=1 and the FIFO is full.
- Accept: a transaction is accepted on an edge where in_valid & in_ready.
- Stage 1 (edge E0):
  - Registers a, b, op, res, cout plus the golden result.
  - sample_cnt increments at E0 and saturates at all-ones.
- Golden result:
  - ADD: {exp_cout, exp_res} = a+b, 5-bit.
  - SUB: exp_res = (a-b) mod 16; exp_cout = (a<b).
  - AND: a&b, exp_cout=0.
  - OR: a|b, exp_cout=0.
- Stage 2 (edge E1 = E0+1): mismatch = (res!=exp_res) | (cout!=exp_cout). On mismatch:
  - mismatch_cnt increments (saturating).
  - The record is pushed into the FIFO.
  - alarm sets if the new count >= ALARM_THRESH.
- Latency: out_valid rises after E1 if the FIFO was empty. Throughput is 1 transaction/cycle.
- FIFO:
  - First-word-fall-through; out_rec is valid whenever out_valid=1.
  - A pop occurs on an edge where out_valid & out_ready.
  - Push and pop in the same cycle are both honoured, including when full.
- Full, STALL_ON_FULL=0:
  - The record is dropped and overflow set; mismatch_cnt still increments.
- Full, STALL_ON_FULL=1:
  - in_ready=0 while full (count==DEPTH).
  - A pop in the same cycle does not re-enable in_ready combinationally.
  - Transactions already in stage 1 still complete. Stage 1 holds at most 1 entry, so the FIFO reserves 1 slot: in_ready is computed against count >= DEPTH-1 when stage 1 is occupied by a transaction that would mismatch. This mode must never drop.
- Counters hold at all-ones. alarm and overflow clear only via rst or clear.
- clear=1:
  - Next state equals the reset state.
  - Overrides a simultaneous accept, push or pop; the accepted sample is discarded and not counted.
- rst mid-operation: in-flight transactions and FIFO contents are lost, with no partial update.
- out_rec when empty: holds the last popped value (don't care; the bench checks only when out_valid=1).

Decomposition:
- Package alu_chk_pkg:
  - Opcode constants OP_ADD/OP_SUB/OP_AND/OP_OR.
  - Record field widths/offsets, REC_W=20.
  - Golden-result function alu_golden(a,b,op) returning {cout,res}.
- Sub-module alu_chk_fifo:
  - Parameterised width/depth, FWFT, with count output, async active-high reset and synchronous clear.
- Top: pipeline registers, compare, counters, flags.

Test Plan:
- Correct results: ADD 5+3 res=8/c=0; SUB 7-4 res=3/c=0; AND 12&10 res=8; OR 5|10 res=15; SUB 3-5 res=14/c=1 -> sample_cnt=5, mismatch_cnt=0, out_valid=0, alarm=0.
- Trojan ADD 15+15 observed res=15/c=0 -> after 2 edges out_valid=1, out_rec={00,F,F,F,0,E,1}, mismatch_cnt=1, alarm=1 (THRESH=1).
- Back-to-back: OR 3|12 observed c=1, then ADD 9+6 observed res=5/c=1 on consecutive cycles -> two records in order: {11,3,C,F,1,F,0} then {00,9,6,5,1,F,0}.
- Overflow (DEPTH=4, out_ready=0, STALL_ON_FULL=0): 5 mismatches -> FIFO holds the first 4, overflow=1, mismatch_cnt=5. With STALL_ON_FULL=1: in_ready drops, no record is lost, and draining 1 re-enables in_ready.
- Simultaneous push/pop while full -> count stays DEPTH, order preserved, no overflow.
- clear asserted with in_valid=1 and a pending mismatch in stage 1 -> next cycle all counters 0, FIFO empty, flags 0. Also assert rst mid-stream -> outputs at reset values immediately, asynchronously.

Source files
------------

// File: rtl/alu_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_chk_pkg
// Brief    : Opcodes, mismatch record layout and golden model for the checker
// Revision : 1.0 - initial release
// ============================================================================
package alu_chk_pkg;

  localparam int OP_W   = 2;
  localparam int DATA_W = 4;
  localparam int REC_W  = OP_W + 4 * DATA_W + 2;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB = 2'b01;
  localparam logic [OP_W-1:0] OP_AND = 2'b10;
  localparam logic [OP_W-1:0] OP_OR  = 2'b11;

  // Field order is the host-visible record layout, MSB first.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] res;
    logic              cout;
    logic [DATA_W-1:0] exp_res;
    logic              exp_cout;
  } rec_t;

  function automatic logic [DATA_W:0] alu_golden(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [OP_W-1:0]   op
  );
    logic [DATA_W:0] r;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {(a < b), a - b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_chk_fifo.sv
`default_nettype none
// ============================================================================
// Module   : alu_chk_fifo
// Brief    : First-word-fall-through FIFO with occupancy count and sync clear
// Revision : 1.0 - initial release
// ============================================================================
module alu_chk_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic [W-1:0]           wdata_i,
  input  logic                   pop_i,
  output logic [W-1:0]           rdata_o,
  output logic                   valid_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          w_push, w_pop;

  // A pop frees the slot this edge, so a push into a full FIFO is still taken.
  always_comb begin
    w_pop    = pop_i & (count_q != '0);
    w_push   = push_i & ((count_q != CW'(DEPTH)) | w_pop);
    wr_ptr_d = wr_ptr_q + AW'(w_push);
    rd_ptr_d = rd_ptr_q + AW'(w_pop);
    count_d  = count_q + CW'(w_push) - CW'(w_pop);
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (clear_i) begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (w_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
      end
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/alu_result_checker.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_checker
// Brief    : Recomputes ALU results, counts mismatches and queues mismatch records
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_checker
  import alu_chk_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int CNT_W         = 16,
  parameter int ALARM_THRESH  = 1,
  parameter int STALL_ON_FULL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic [1:0]       op,
  input  logic [3:0]       res,
  input  logic             cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REC_W-1:0] out_rec,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             alarm,
  output logic             overflow
);

  localparam int FCW = $clog2(DEPTH) + 1;

  rec_t             s1_rec_q, s1_rec_d;
  logic             s1_valid_q, s1_valid_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
  logic             alarm_q, alarm_d;
  logic             overflow_q, overflow_d;

  logic [DATA_W:0]    w_golden;
  logic               w_accept, w_mismatch, w_pop, w_drop;
  logic               w_fifo_full;
  logic [FCW-1:0]     w_fifo_count;
  logic [REC_W-1:0]   w_fifo_rdata;

  assign w_accept   = in_valid & in_ready;
  assign w_mismatch = s1_valid_q & ((s1_rec_q.res  != s1_rec_q.exp_res) |
                                    (s1_rec_q.cout != s1_rec_q.exp_cout));
  assign w_pop      = out_valid & out_ready;
  assign w_drop     = w_mismatch & w_fifo_full & ~w_pop;

  // One slot is held back for a mismatch already sitting in stage 1.
  generate
    if (STALL_ON_FULL != 0) begin : g_stall
      assign in_ready = ~(w_fifo_full |
                          (w_mismatch & (w_fifo_count >= FCW'(DEPTH - 1))));
    end else begin : g_drop
      assign in_ready = 1'b1;
    end
  endgenerate

  always_comb begin
    w_golden   = alu_golden(a, b, op);
    s1_valid_d = w_accept & ~clear;
    s1_rec_d   = s1_rec_q;
    if (w_accept) begin
      s1_rec_d.op       = op;
      s1_rec_d.a        = a;
      s1_rec_d.b        = b;
      s1_rec_d.res      = res;
      s1_rec_d.cout     = cout;
      s1_rec_d.exp_res  = w_golden[DATA_W-1:0];
      s1_rec_d.exp_cout = w_golden[DATA_W];
    end

    sample_cnt_d = sample_cnt_q;
    if (w_accept && (sample_cnt_q != '1)) sample_cnt_d = sample_cnt_q + CNT_W'(1);

    mismatch_cnt_d = mismatch_cnt_q;
    if (w_mismatch && (mismatch_cnt_q != '1)) mismatch_cnt_d = mismatch_cnt_q + CNT_W'(1);

    alarm_d    = alarm_q | (mismatch_cnt_d >= CNT_W'(ALARM_THRESH));
    overflow_d = overflow_q | w_drop;

    if (clear) begin
      s1_rec_d       = '0;
      sample_cnt_d   = '0;
      mismatch_cnt_d = '0;
      alarm_d        = 1'b0;
      overflow_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q     <= 1'b0;
      s1_rec_q       <= '0;
      sample_cnt_q   <= '0;
      mismatch_cnt_q <= '0;
      alarm_q        <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_rec_q       <= s1_rec_d;
      sample_cnt_q   <= sample_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      alarm_q        <= alarm_d;
      overflow_q     <= overflow_d;
    end
  end

  alu_chk_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear),
    .push_i  (w_mismatch & ~clear),
    .wdata_i (s1_rec_q),
    .pop_i   (w_pop & ~clear),
    .rdata_o (w_fifo_rdata),
    .valid_o (out_valid),
    .full_o  (w_fifo_full),
    .count_o (w_fifo_count)
  );

  assign out_rec      = w_fifo_rdata;
  assign sample_cnt   = sample_cnt_q;
  assign mismatch_cnt = mismatch_cnt_q;
  assign alarm        = alarm_q;
  assign overflow     = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_checker
// Brief    : Scoreboard bench for the drop-mode and stall-mode checker variants
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_checker;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_valid2 = 1'b0, out_ready2 = 1'b0;
  logic [3:0] a = '0, b = '0, res = '0;
  logic [1:0] op = '0;
  logic cout = 1'b0;

  logic in_ready, out_valid, alarm, overflow;
  logic [19:0] out_rec;
  logic [15:0] sample_cnt, mismatch_cnt;
  logic in_ready2, out_valid2, alarm2, overflow2;
  logic [19:0] out_rec2;
  logic [15:0] sample_cnt2, mismatch_cnt2;

  int errors = 0;
  int checks = 0;
  logic [19:0] q1[$];
  logic [19:0] q2[$];
  int exp_m1 = 0, exp_s1 = 0, exp_m2 = 0, exp_s2 = 0;

  always #5 clk = ~clk;

  alu_result_checker #(.DEPTH(DEPTH), .CNT_W(16), .ALARM_THRESH(1), .STALL_ON_FULL(0)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .res(res), .cout(cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_rec(out_rec),
    .sample_cnt(sample_cnt), .mismatch_cnt(mismatch_cnt), .alarm(alarm), .overflow(overflow)
  );

  alu_result_checker #(.DEPTH(DEPTH), .CNT_W(16), .ALARM_THRESH(3), .STALL_ON_FULL(1)) u_dut_stall (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a), .b(b), .op(op), .res(res), .cout(cout),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_rec(out_rec2),
    .sample_cnt(sample_cnt2), .mismatch_cnt(mismatch_cnt2), .alarm(alarm2), .overflow(overflow2)
  );

  // Reference ALU in integer arithmetic; returns {carry/borrow, result}.
  function automatic logic [4:0] model(input logic [3:0] xa, input logic [3:0] xb, input logic [1:0] xop);
    int x, y, r;
    x = int'(xa);
    y = int'(xb);
    case (xop)
      2'd0:    r = x + y;
      2'd1:    r = (x < y) ? (x - y + 32) : (x - y);
      2'd2:    r = x & y;
      default: r = x | y;
    endcase
    return r[4:0];
  endfunction

  function automatic logic [19:0] mkrec(input logic [3:0] xa, input logic [3:0] xb, input logic [1:0] xop,
                                        input logic [3:0] xr, input logic xc);
    logic [4:0] e;
    e = model(xa, xb, xop);
    return {xop, xa, xb, xr, xc, e[3:0], e[4]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] xa, input logic [3:0] xb, input logic [1:0] xop,
                       input logic [3:0] xr, input logic xc);
    a = xa; b = xb; op = xop; res = xr; cout = xc;
  endtask

  task automatic send1(input logic [3:0] xa, input logic [3:0] xb, input logic [1:0] xop,
                       input logic [3:0] xr, input logic xc);
    drive(xa, xb, xop, xr, xc);
    in_valid = 1'b1;
    if ({xc, xr} != model(xa, xb, xop)) begin
      q1.push_back(mkrec(xa, xb, xop, xr, xc));
      exp_m1++;
    end
    exp_s1++;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic send2(input logic [3:0] xa, input logic [3:0] xb, input logic [1:0] xop,
                       input logic [3:0] xr, input logic xc);
    drive(xa, xb, xop, xr, xc);
    in_valid2 = 1'b1;
    if ({xc, xr} != model(xa, xb, xop)) begin
      q2.push_back(mkrec(xa, xb, xop, xr, xc));
      exp_m2++;
    end
    exp_s2++;
    cyc();
    in_valid2 = 1'b0;
  endtask

  task automatic send1_bad(input logic [3:0] xa, input logic [3:0] xb, input logic [1:0] xop);
    logic [4:0] e;
    e = model(xa, xb, xop);
    send1(xa, xb, xop, e[3:0] ^ 4'h1, e[4]);
  endtask

  task automatic send2_bad(input logic [3:0] xa, input logic [3:0] xb, input logic [1:0] xop);
    logic [4:0] e;
    e = model(xa, xb, xop);
    send2(xa, xb, xop, e[3:0] ^ 4'h1, e[4]);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    out_ready = 1'b0;
    out_ready2 = 1'b0;
    q1.delete();
    q2.delete();
    exp_m1 = 0; exp_s1 = 0; exp_m2 = 0; exp_s2 = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL reset_in_ready2 got=%b want=1", in_ready2); end
    checks++; if (out_rec !== 20'h0) begin errors++; $display("FAIL reset_out_rec got=%h want=0", out_rec); end
    checks++; if (sample_cnt !== 16'd0 || mismatch_cnt !== 16'd0) begin errors++;
      $display("FAIL reset_counts got=%0d/%0d want=0/0", sample_cnt, mismatch_cnt); end
    checks++; if (alarm !== 1'b0 || overflow !== 1'b0) begin errors++;
      $display("FAIL reset_flags got=%b%b want=00", alarm, overflow); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_correct();
    send1(4'd5, 4'd3, 2'd0, 4'd8, 1'b0);
    send1(4'd7, 4'd4, 2'd1, 4'd3, 1'b0);
    send1(4'd12, 4'd10, 2'd2, 4'd8, 1'b0);
    send1(4'd5, 4'd10, 2'd3, 4'd15, 1'b0);
    send1(4'd3, 4'd5, 2'd1, 4'd14, 1'b1);
    cyc();
    checks++; if (sample_cnt !== 16'd5) begin errors++; $display("FAIL correct_samples got=%0d want=5", sample_cnt); end
    checks++; if (mismatch_cnt !== 16'd0) begin errors++; $display("FAIL correct_mismatch got=%0d want=0", mismatch_cnt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL correct_out_valid got=%b want=0", out_valid); end
    checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL correct_alarm got=%b want=0", alarm); end
  endtask

  task automatic test_trojan();
    logic [19:0] want;
    send1(4'hF, 4'hF, 2'd0, 4'hF, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL trojan_early got=%b want=0", out_valid); end
    cyc();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL trojan_out_valid got=%b want=1", out_valid); end
    want = q1.pop_front();
    checks++; if (out_rec !== want) begin errors++; $display("FAIL trojan_rec got=%h want=%h", out_rec, want); end
    checks++; if (mismatch_cnt !== 16'd1) begin errors++; $display("FAIL trojan_mismatch got=%0d want=1", mismatch_cnt); end
    checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL trojan_alarm got=%b want=1", alarm); end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL trojan_popped got=%b want=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [19:0] want;
    send1(4'd3, 4'hC, 2'd3, 4'hF, 1'b1);
    send1(4'd9, 4'd6, 2'd0, 4'd5, 1'b1);
    cyc();
    for (int i = 0; i < 2; i++) begin
      want = q1.pop_front();
      checks++; if (out_valid !== 1'b1 || out_rec !== want) begin errors++;
        $display("FAIL b2b_rec%0d got=%b/%h want=1/%h", i, out_valid, out_rec, want); end
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%b want=0", out_valid); end
    checks++; if (mismatch_cnt !== 16'(exp_m1)) begin errors++;
      $display("FAIL b2b_mismatch got=%0d want=%0d", mismatch_cnt, exp_m1); end
  endtask

  task automatic test_full_pushpop();
    logic [19:0] want;
    do_clear();
    for (int i = 0; i < DEPTH; i++) send1_bad(4'(i + 1), 4'd2, 2'(i));
    cyc();
    send1_bad(4'd11, 4'd13, 2'd1);
    want = q1.pop_front();
    checks++; if (out_rec !== want) begin errors++; $display("FAIL fullpp_head got=%h want=%h", out_rec, want); end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpp_overflow got=%b want=0", overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      want = q1.pop_front();
      checks++; if (out_valid !== 1'b1 || out_rec !== want) begin errors++;
        $display("FAIL fullpp_rec%0d got=%b/%h want=1/%h", i, out_valid, out_rec, want); end
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fullpp_empty got=%b want=0", out_valid); end
  endtask

  task automatic test_overflow();
    logic [19:0] want;
    do_clear();
    for (int i = 0; i < 5; i++) send1_bad(4'(3 * i), 4'(i), 2'(i));
    cyc();
    want = q1.pop_back();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b want=1", overflow); end
    checks++; if (mismatch_cnt !== 16'd5) begin errors++; $display("FAIL ovf_mismatch got=%0d want=5", mismatch_cnt); end
    checks++; if (sample_cnt !== 16'(exp_s1)) begin errors++; $display("FAIL ovf_samples got=%0d want=%0d", sample_cnt, exp_s1); end
    for (int i = 0; i < DEPTH; i++) begin
      want = q1.pop_front();
      checks++; if (out_valid !== 1'b1 || out_rec !== want) begin errors++;
        $display("FAIL ovf_rec%0d got=%b/%h want=1/%h", i, out_valid, out_rec, want); end
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%b want=0", out_valid); end
  endtask

  task automatic test_clear();
    logic [4:0] e;
    send1_bad(4'd6, 4'd1, 2'd0);
    e = model(4'd8, 4'd9, 2'd1);
    drive(4'd8, 4'd9, 2'd1, ~e[3:0], e[4]);
    in_valid = 1'b1;
    cyc();
    drive(4'd1, 4'd1, 2'd0, 4'd0, 1'b1);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    in_valid = 1'b0;
    q1.delete(); exp_m1 = 0; exp_s1 = 0;
    checks++; if (sample_cnt !== 16'd0 || mismatch_cnt !== 16'd0) begin errors++;
      $display("FAIL clear_counts got=%0d/%0d want=0/0", sample_cnt, mismatch_cnt); end
    checks++; if (alarm !== 1'b0 || overflow !== 1'b0) begin errors++;
      $display("FAIL clear_flags got=%b%b want=00", alarm, overflow); end
    checks++; if (out_valid !== 1'b0 || out_rec !== 20'h0) begin errors++;
      $display("FAIL clear_fifo got=%b/%h want=0/0", out_valid, out_rec); end
    cyc();
    checks++; if (out_valid !== 1'b0 || mismatch_cnt !== 16'd0 || sample_cnt !== 16'd0) begin errors++;
      $display("FAIL clear_pipe got=%b/%0d/%0d want=0/0/0", out_valid, mismatch_cnt, sample_cnt); end
  endtask

  task automatic test_threshold();
    do_clear();
    send2_bad(4'd2, 4'd7, 2'd1);
    send2_bad(4'd9, 4'd9, 2'd0);
    cyc();
    checks++; if (mismatch_cnt2 !== 16'd2 || alarm2 !== 1'b0) begin errors++;
      $display("FAIL thresh_below got=%0d/%b want=2/0", mismatch_cnt2, alarm2); end
    send2_bad(4'd4, 4'd5, 2'd3);
    cyc();
    checks++; if (mismatch_cnt2 !== 16'd3 || alarm2 !== 1'b1) begin errors++;
      $display("FAIL thresh_at got=%0d/%b want=3/1", mismatch_cnt2, alarm2); end
    checks++; if (sample_cnt2 !== 16'(exp_s2)) begin errors++;
      $display("FAIL thresh_samples got=%0d want=%0d", sample_cnt2, exp_s2); end
  endtask

  task automatic test_stall();
    logic [19:0] want;
    logic [4:0] e;
    int acc;
    do_clear();
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      e = model(4'(i), 4'(15 - i), 2'd0);
      drive(4'(i), 4'(15 - i), 2'd0, e[3:0] ^ 4'h8, e[4]);
      in_valid2 = 1'b1;
      if (in_ready2 === 1'b1) begin
        q2.push_back(mkrec(4'(i), 4'(15 - i), 2'd0, e[3:0] ^ 4'h8, e[4]));
        acc++; exp_m2++; exp_s2++;
      end
      cyc();
    end
    in_valid2 = 1'b0;
    checks++; if (acc != DEPTH) begin errors++; $display("FAIL stall_accepted got=%0d want=%0d", acc, DEPTH); end
    checks++; if (in_ready2 !== 1'b0) begin errors++; $display("FAIL stall_ready_low got=%b want=0", in_ready2); end
    checks++; if (overflow2 !== 1'b0) begin errors++; $display("FAIL stall_overflow got=%b want=0", overflow2); end
    checks++; if (mismatch_cnt2 !== 16'(exp_m2) || alarm2 !== 1'b1) begin errors++;
      $display("FAIL stall_counts got=%0d/%b want=%0d/1", mismatch_cnt2, alarm2, exp_m2); end
    out_ready2 = 1'b1;
    #1;
    checks++; if (in_ready2 !== 1'b0) begin errors++; $display("FAIL stall_same_cycle got=%b want=0", in_ready2); end
    want = q2.pop_front();
    checks++; if (out_rec2 !== want) begin errors++; $display("FAIL stall_rec0 got=%h want=%h", out_rec2, want); end
    cyc();
    out_ready2 = 1'b0;
    checks++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL stall_reenable got=%b want=1", in_ready2); end
    for (int i = 1; i < DEPTH; i++) begin
      want = q2.pop_front();
      checks++; if (out_valid2 !== 1'b1 || out_rec2 !== want) begin errors++;
        $display("FAIL stall_rec%0d got=%b/%h want=1/%h", i, out_valid2, out_rec2, want); end
      out_ready2 = 1'b1;
      cyc();
      out_ready2 = 1'b0;
    end
    checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL stall_empty got=%b want=0", out_valid2); end
  endtask

  task automatic test_async_rst();
    send1_bad(4'd10, 4'd3, 2'd2);
    cyc();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre got=%b want=1", out_valid); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_rec !== 20'h0) begin errors++;
      $display("FAIL arst_fifo got=%b/%h want=0/0", out_valid, out_rec); end
    checks++; if (sample_cnt !== 16'd0 || mismatch_cnt !== 16'd0 || alarm !== 1'b0) begin errors++;
      $display("FAIL arst_state got=%0d/%0d/%b want=0/0/0", sample_cnt, mismatch_cnt, alarm); end
    #2;
    rst = 1'b0;
    cyc();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL arst_after got=%b/%b want=0/1", out_valid, in_ready); end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_trojan();
    test_back_to_back();
    test_full_pushpop();
    test_overflow();
    test_clear();
    test_threshold();
    test_stall();
    test_async_rst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
